lcd_char_display_ctrl: RTL and testbench

Parametrised HD44780-style character-LCD controller. It holds an internal NUM_ROWS x NUM_COLS character buffer that the system writes one character at a time at any moment. A paced refresh engine initialises the panel, then rewrites only the rows marked dirty, each preceded by a DDRAM set-address command. It is the successor to the fixed 16x2 controller and adds 1/2/4-row support, random-access writes, clear, and busy/done status.

---
 rtl/lcd_char_display_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_char_display_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_display_ctrl.sv
// Character-LCD (HD44780-style) controller with an internal NUM_ROWS x NUM_COLS
// character buffer. A tick-paced engine initialises the panel and then rewrites
// only the rows marked dirty, each preceded by a DDRAM set-address command.
//
// Write port: wr_en_i is a one-clk strobe with no ready. A write is accepted
// in every state. An in-range write lands in the buffer on the next clk. An
// out-of-range write is dropped and answered by a one-clk wr_err_o pulse.
module lcd_char_display_ctrl #(
  parameter int NUM_COLS  = 16,
  parameter int NUM_ROWS  = 2,
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 800000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init_i,
  input  logic                      wr_en_i,
  input  logic [1:0]                wr_row_i,
  input  logic [$clog2(NUM_COLS):0] wr_col_i,
  input  logic [DATA_BITS-1:0]      wr_char_i,
  input  logic                      clear_i,
  output logic                      wr_err_o,
  output logic                      busy_o,
  output logic                      init_done_o,
  output logic                      rs,
  output logic                      rw,
  output logic                      enable,
  output logic [DATA_BITS-1:0]      data,
  output logic [2:0]                state_dbg
);

  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_SLOTS = 1 << ROW_W;
  localparam int COL_SLOTS = 1 << COL_W;
  localparam int CNT_W     = $clog2(CLK_DIV);
  localparam logic [ROW_SLOTS-1:0] ROW_MASK = ROW_SLOTS'((1 << NUM_ROWS) - 1);
  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [DATA_BITS-1:0] SPACE    = DATA_BITS'(8'h20);

  if (!(NUM_ROWS == 1 || NUM_ROWS == 2 || NUM_ROWS == 4)) begin : g_bad_rows
    $error("lcd_char_display_ctrl: NUM_ROWS must be 1, 2 or 4");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("lcd_char_display_ctrl: CLK_DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_READY    = 3'd2,
    S_SET_ADDR = 3'd3,
    S_WR_ROW   = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       tick_cnt;
  logic                   tick, tick_b;
  logic                   phase_b;      // 0: next tick is Tick A, 1: next is Tick B
  logic [1:0]             init_idx;
  logic [COL_W-1:0]       col_idx;
  logic [ROW_W-1:0]       cur_row, lowest_row;
  logic [ROW_SLOTS-1:0]   dirty, dirty_next;
  logic                   in_range, wr_ok;
  logic [ROW_W-1:0]       wr_row_idx;
  logic [COL_W-1:0]       wr_col_idx;
  logic [DATA_BITS-1:0]   char_buf [ROW_SLOTS][COL_SLOTS];

  assign tick       = (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign tick_b     = tick && phase_b;
  assign in_range   = (int'(wr_row_i) < NUM_ROWS) && (int'(wr_col_i) < NUM_COLS);
  assign wr_ok      = wr_en_i && in_range;
  assign wr_row_idx = wr_row_i[ROW_W-1:0];
  assign wr_col_idx = wr_col_i[COL_W-1:0];
  assign rw         = 1'b0;

  function automatic logic [DATA_BITS-1:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return DATA_BITS'(8'h38);
      2'd1:    return DATA_BITS'(8'h06);
      2'd2:    return DATA_BITS'(8'h0C);
      default: return DATA_BITS'(8'h01);
    endcase
  endfunction

  function automatic logic [DATA_BITS-1:0] addr_cmd(input logic [ROW_W-1:0] r);
    case (int'(r))
      0:       return DATA_BITS'(8'h80);
      1:       return DATA_BITS'(8'hC0);
      2:       return DATA_BITS'(8'h94);
      default: return DATA_BITS'(8'hD4);
    endcase
  endfunction

  // Lowest-index dirty row: the next row the refresh engine will serve.
  always_comb begin
    lowest_row = '0;
    for (int r = ROW_SLOTS - 1; r >= 0; r--) begin
      if (dirty[r]) lowest_row = ROW_W'(r);
    end
  end

  // Dirty-bit update; later lines take priority, so a write always re-marks its row.
  always_comb begin
    dirty_next = dirty;
    if (tick && !phase_b && state == S_SET_ADDR) dirty_next[lowest_row] = 1'b0;
    if (tick_b && state == S_INIT && init_idx == 2'd3) dirty_next = ROW_MASK;
    if (clear_i && init_done_o) dirty_next = ROW_MASK;
    if (wr_ok) dirty_next[wr_row_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; every transition happens on a tick.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (tick && init_i) state_next = S_INIT;
      S_INIT:     if (tick_b && init_idx == 2'd3) state_next = S_READY;
      S_READY:    if (tick && (|dirty)) state_next = S_SET_ADDR;
      S_SET_ADDR: if (tick_b) state_next = S_WR_ROW;
      S_WR_ROW:   if (tick_b && col_idx == LAST_COL)
                    state_next = (|dirty_next) ? S_SET_ADDR : S_READY;
      default:    state_next = S_IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy_o    = (state == S_INIT) || (state == S_SET_ADDR) || (state == S_WR_ROW);
    state_dbg = state;
  end

  // Tick divider and the two-tick transfer engine driving the LCD pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      phase_b     <= 1'b0;
      init_idx    <= 2'd0;
      col_idx     <= '0;
      cur_row     <= '0;
      init_done_o <= 1'b0;
      rs          <= 1'b0;
      enable      <= 1'b0;
      data        <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && busy_o) begin
        phase_b <= ~phase_b;
        if (!phase_b) begin
          enable <= 1'b1;
          case (state)
            S_INIT: begin
              rs   <= 1'b0;
              data <= init_cmd(init_idx);
            end
            S_SET_ADDR: begin
              rs      <= 1'b0;
              data    <= addr_cmd(lowest_row);
              cur_row <= lowest_row;
            end
            default: begin
              rs   <= 1'b1;
              data <= char_buf[cur_row][col_idx];
            end
          endcase
        end else begin
          enable <= 1'b0;
          case (state)
            S_INIT: begin
              init_idx <= init_idx + 2'd1;
              if (init_idx == 2'd3) init_done_o <= 1'b1;
            end
            S_SET_ADDR: col_idx <= '0;
            default:    col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
          endcase
        end
      end
    end
  end

  // Character buffer: clear fills with spaces, a coinciding write then wins its cell.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int r = 0; r < ROW_SLOTS; r++) begin
        for (int c = 0; c < COL_SLOTS; c++) char_buf[r][c] <= SPACE;
      end
    end
    if (!reset && wr_ok) char_buf[wr_row_idx][wr_col_idx] <= wr_char_i;
  end

  // Dirty bits and the out-of-range write pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty    <= '0;
      wr_err_o <= 1'b0;
    end else begin
      dirty    <= dirty_next;
      wr_err_o <= wr_en_i && !in_range;
    end
  end

endmodule

// File: tb/tb_lcd_char_display_ctrl.sv
// Bench for lcd_char_display_ctrl: a 2x16 instance (main) and a 4x20 instance
// (four-row addressing and clear). Expected traffic is built from a character
// model; a virtual panel replays the LCD bus to check the final screen image.
module tb_lcd_char_display_ctrl;

  localparam int CLK_DIV = 4;
  localparam int A_COLS  = 16;
  localparam int A_ROWS  = 2;
  localparam int B_COLS  = 20;
  localparam int B_ROWS  = 4;
  localparam int QUIET   = 3 * CLK_DIV + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, init_a, wr_en_a, clear_a;
  logic [1:0] wr_row_a;
  logic [4:0] wr_col_a;
  logic [7:0] wr_char_a;
  logic       wr_err_a, busy_a, init_done_a, rs_a, rw_a, enable_a;
  logic [7:0] data_a;
  logic [2:0] state_a;

  logic       reset_b, init_b, wr_en_b, clear_b;
  logic [1:0] wr_row_b;
  logic [5:0] wr_col_b;
  logic [7:0] wr_char_b;
  logic       wr_err_b, busy_b, init_done_b, rs_b, rw_b, enable_b;
  logic [7:0] data_b;
  logic [2:0] state_b;

  lcd_char_display_ctrl #(.NUM_COLS(A_COLS), .NUM_ROWS(A_ROWS), .DATA_BITS(8), .CLK_DIV(CLK_DIV)) dut_a (
    .clk(clk), .reset(reset_a), .init_i(init_a), .wr_en_i(wr_en_a), .wr_row_i(wr_row_a),
    .wr_col_i(wr_col_a), .wr_char_i(wr_char_a), .clear_i(clear_a), .wr_err_o(wr_err_a),
    .busy_o(busy_a), .init_done_o(init_done_a), .rs(rs_a), .rw(rw_a), .enable(enable_a),
    .data(data_a), .state_dbg(state_a));

  lcd_char_display_ctrl #(.NUM_COLS(B_COLS), .NUM_ROWS(B_ROWS), .DATA_BITS(8), .CLK_DIV(CLK_DIV)) dut_b (
    .clk(clk), .reset(reset_b), .init_i(init_b), .wr_en_i(wr_en_b), .wr_row_i(wr_row_b),
    .wr_col_i(wr_col_b), .wr_char_i(wr_char_b), .clear_i(clear_b), .wr_err_o(wr_err_b),
    .busy_o(busy_b), .init_done_o(init_done_b), .rs(rs_b), .rw(rw_b), .enable(enable_b),
    .data(data_b), .state_dbg(state_b));

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] obs_a[$];
  logic [8:0] obs_b[$];
  int         hi_q[$];
  int         lo_q[$];
  int         run_a, falls_a;
  logic       prev_en_a, prev_en_b;
  logic [7:0] model_a [A_ROWS][A_COLS];
  logic [7:0] ddram [128];
  logic [6:0] lcd_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- bus monitors (negedge, away from the active edge) ----------------
  always @(negedge clk) begin
    if (reset_a) begin
      obs_a.delete(); hi_q.delete(); lo_q.delete();
      run_a = 0; falls_a = 0; prev_en_a = 1'b0;
    end else begin
      if (enable_a && !prev_en_a) begin
        obs_a.push_back({rs_a, data_a});
        lo_q.push_back(run_a);
        run_a = 1;
        if (!rs_a && data_a == 8'h01) begin
          for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
          lcd_addr = 7'd0;
        end else if (!rs_a && data_a[7]) begin
          lcd_addr = data_a[6:0];
        end else if (rs_a) begin
          ddram[lcd_addr] = data_a;
          lcd_addr = lcd_addr + 7'd1;
        end
      end else if (!enable_a && prev_en_a) begin
        hi_q.push_back(run_a);
        run_a = 1;
        falls_a++;
      end else begin
        run_a++;
      end
      prev_en_a = enable_a;
    end
  end

  always @(negedge clk) begin
    if (reset_b) begin
      obs_b.delete(); prev_en_b = 1'b0;
    end else begin
      if (enable_b && !prev_en_b) obs_b.push_back({rs_b, data_b});
      prev_en_b = enable_b;
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [7:0] base_of(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  task automatic model_reset_a();
    for (int r = 0; r < A_ROWS; r++)
      for (int c = 0; c < A_COLS; c++) model_a[r][c] = 8'h20;
  endtask

  task automatic push_init_a();
    exp_a.push_back({1'b0, 8'h38}); exp_a.push_back({1'b0, 8'h06});
    exp_a.push_back({1'b0, 8'h0C}); exp_a.push_back({1'b0, 8'h01});
  endtask

  task automatic push_row_a(input int r);
    exp_a.push_back({1'b0, 8'h80 | base_of(r)});
    for (int c = 0; c < A_COLS; c++) exp_a.push_back({1'b1, model_a[r][c]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_a(input int r, input int c, input logic [7:0] ch);
    logic ok;
    ok = (r < A_ROWS) && (c < A_COLS);
    step();
    wr_en_a = 1'b1; wr_row_a = r[1:0]; wr_col_a = c[4:0]; wr_char_a = ch;
    step();
    wr_en_a = 1'b0;
    check("wr_err", wr_err_a, {31'd0, !ok});
    if (ok) model_a[r][c] = ch;
  endtask

  task automatic wait_quiet(input bit use_b);
    int quiet = 0;
    int t = 0;
    while (quiet < QUIET && t < 4000) begin
      step();
      t++;
      quiet = (use_b ? busy_b : busy_a) ? 0 : quiet + 1;
    end
    check(use_b ? "quiet_b" : "quiet_a", (quiet >= QUIET), 1);
  endtask

  task automatic wait_init_done_a();
    int t = 0;
    while (!init_done_a && t < 2000) begin
      step();
      t++;
    end
    check("init_done", init_done_a, 1);
  endtask

  task automatic compare_a(input string tag);
    check({tag, "_len"}, obs_a.size(), exp_a.size());
    while (exp_a.size() > 0 && obs_a.size() > 0) check(tag, obs_a.pop_front(), exp_a.pop_front());
    obs_a.delete(); exp_a.delete();
  endtask

  task automatic compare_b(input string tag);
    check({tag, "_len"}, obs_b.size(), exp_b.size());
    while (exp_b.size() > 0 && obs_b.size() > 0) check(tag, obs_b.pop_front(), exp_b.pop_front());
    obs_b.delete(); exp_b.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int r, c;
    logic [7:0] ch;
    reset_a = 1'b1; init_a = 1'b0; wr_en_a = 1'b0; clear_a = 1'b0;
    wr_row_a = '0; wr_col_a = '0; wr_char_a = '0;
    reset_b = 1'b1; init_b = 1'b0; wr_en_b = 1'b0; clear_b = 1'b0;
    wr_row_b = '0; wr_col_b = '0; wr_char_b = '0;
    lcd_addr = 7'd0;
    for (int i = 0; i < 128; i++) ddram[i] = 8'h00;
    model_reset_a();
    repeat (3) step();

    check("rst_enable", enable_a, 0);
    check("rst_data", data_a, 0);
    check("rst_rs", rs_a, 0);
    check("rst_rw", rw_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_init_done", init_done_a, 0);
    check("rst_wr_err", wr_err_a, 0);
    check("rst_state", state_a, 0);
    reset_a = 1'b0; reset_b = 1'b0;

    // Write accepted while IDLE; shows up in the first refresh after init.
    write_a(0, 2, 8'h5A);
    check("idle_state", state_a, 0);

    // Initialisation and the full-screen refresh that follows it.
    init_a = 1'b1; init_b = 1'b1;
    wait_init_done_a();
    check("init_falls", falls_a, 4);
    init_a = 1'b0; init_b = 1'b0;
    for (int i = 0; i < 4; i++) check("init_en_high", hi_q[i], CLK_DIV);
    for (int i = 1; i < 4; i++) check("init_en_low", lo_q[i], CLK_DIV);
    push_init_a(); push_row_a(0); push_row_a(1);
    wait_quiet(1'b0);
    compare_a("init_seq");
    check("ready_state", state_a, 2);
    check("ready_busy", busy_a, 0);

    // Single write: only row1 refreshed.
    write_a(1, 3, 8'h41);
    push_row_a(1);
    wait_quiet(1'b0);
    compare_a("row1_only");

    // Out-of-range writes: error pulse, no refresh, stays READY.
    write_a(2, 0, 8'($urandom_range(33, 126)));
    write_a(0, 16, 8'($urandom_range(33, 126)));
    write_a(3, $urandom_range(0, 15), 8'($urandom_range(33, 126)));
    step();
    check("wr_err_drop", wr_err_a, 0);
    wait_quiet(1'b0);
    compare_a("oor_none");
    check("oor_state", state_a, 2);

    // Writes landing during a row1 refresh (after its column 7 was sent).
    write_a(1, $urandom_range(0, 15), 8'($urandom_range(33, 126)));
    push_row_a(1);
    t = 0;
    while (obs_a.size() < 9 && t < 1000) begin
      step();
      t++;
    end
    check("mid_reach", (obs_a.size() >= 9), 1);
    write_a(0, 0, 8'($urandom_range(33, 126)));
    write_a(1, 5, 8'($urandom_range(33, 126)));
    push_row_a(0); push_row_a(1);
    wait_quiet(1'b0);
    compare_a("mid_refresh");

    // Random writes at random times; the panel image must match the model.
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 40)) step();
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 17);
      ch = 8'($urandom_range(33, 126));
      write_a(r, c, ch);
    end
    wait_quiet(1'b0);
    for (int rr = 0; rr < A_ROWS; rr++)
      for (int cc = 0; cc < A_COLS; cc++)
        check("panel", ddram[int'(base_of(rr)) + cc], model_a[rr][cc]);
    obs_a.delete();

    // 4x20 instance: clear after init refreshes all four rows with spaces.
    wait_quiet(1'b1);
    check("b_init_done", init_done_b, 1);
    obs_b.delete();
    step(); clear_b = 1'b1;
    step(); clear_b = 1'b0;
    for (int rr = 0; rr < B_ROWS; rr++) begin
      exp_b.push_back({1'b0, 8'h80 | base_of(rr)});
      for (int cc = 0; cc < B_COLS; cc++) exp_b.push_back({1'b1, 8'h20});
    end
    wait_quiet(1'b1);
    compare_b("b_clear");

    // Reset at Tick B of the third init command, then a clean re-init.
    reset_a = 1'b1;
    step(); step();
    reset_a = 1'b0;
    model_reset_a();
    init_a = 1'b1;
    t = 0;
    while (falls_a < 3 && t < 1000) begin
      step();
      t++;
    end
    check("mid_rst_falls", falls_a, 3);
    reset_a = 1'b1;
    step();
    check("mid_rst_enable", enable_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_state", state_a, 0);
    check("mid_rst_init_done", init_done_a, 0);
    reset_a = 1'b0;
    wait_init_done_a();
    init_a = 1'b0;
    push_init_a(); push_row_a(0); push_row_a(1);
    wait_quiet(1'b0);
    compare_a("reinit");

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
